// File: rtl/uart_rx_fifo_if.sv
// RX byte hand-off between the UART core, the receive FIFO and the register block.
// Latency: none; wires only.
// Backpressure: push side has none; the pop side uses the o_rd_valid/i_rd_ready handshake.
interface uart_rx_fifo_if #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_FIFO_AWIDTH     = 4
);
  logic [P_UART_DATA_WIDTH-1:0] i_wr_data;
  logic                         i_wr_valid;
  logic [P_UART_DATA_WIDTH-1:0] o_rd_data;
  logic                         o_rd_valid;
  logic                         i_rd_ready;
  logic [P_FIFO_AWIDTH:0]       o_count;
  logic                         o_full;
  logic                         o_empty;
  logic                         o_overflow;
  logic                         i_ovf_clear;
  logic                         i_flush;
  logic                         o_irq;

  // Driver side: UART core plus register block.
  modport master (
    output i_wr_data, i_wr_valid, i_rd_ready, i_ovf_clear, i_flush,
    input  o_rd_data, o_rd_valid, o_count, o_full, o_empty, o_overflow, o_irq
  );

  // FIFO side.
  modport slave (
    input  i_wr_data, i_wr_valid, i_rd_ready, i_ovf_clear, i_flush,
    output o_rd_data, o_rd_valid, o_count, o_full, o_empty, o_overflow, o_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with level, sticky overflow and threshold irq.
// Latency: a byte pushed at edge N is visible on o_rd_data after edge N; no same-cycle bypass.
// Backpressure: none on push (drops when full, sets overflow); pops on o_rd_valid & i_rd_ready.
module uart_rx_fifo #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_FIFO_AWIDTH     = 4,
  parameter int P_IRQ_LEVEL       = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_rx_fifo_if.slave        bus
);
  localparam int                   DEPTH     = 2 ** P_FIFO_AWIDTH;
  localparam logic [P_FIFO_AWIDTH:0] DEPTH_CNT = (P_FIFO_AWIDTH+1)'(DEPTH);
  localparam logic [P_FIFO_AWIDTH:0] IRQ_LVL   = (P_FIFO_AWIDTH+1)'(P_IRQ_LEVEL);

  logic [P_UART_DATA_WIDTH-1:0] mem [DEPTH];
  logic [P_FIFO_AWIDTH-1:0]     wr_ptr;
  logic [P_FIFO_AWIDTH-1:0]     rd_ptr;
  logic [P_FIFO_AWIDTH:0]       count;
  logic                         overflow;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic ovf_evt;

  // Handshake decode; flush discards both a push and a pop in its cycle.
  always_comb begin
    full    = (count == DEPTH_CNT);
    empty   = (count == '0);
    pop     = !empty && bus.i_rd_ready && !bus.i_flush;
    push    = bus.i_wr_valid && (!full || pop) && !bus.i_flush;
    ovf_evt = bus.i_wr_valid && full && !pop && !bus.i_flush;
  end

  // Storage array is not reset; contents are only meaningful below count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_FIFO_AWIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + P_FIFO_AWIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (P_FIFO_AWIDTH+1)'(1);
        2'b01:   count <= count - (P_FIFO_AWIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_evt) begin
      overflow <= 1'b1;
    end else if (bus.i_ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  // Status outputs derived from the registered count; data is a direct read of the head.
  always_comb begin
    bus.o_rd_data  = mem[rd_ptr];
    bus.o_rd_valid = !empty;
    bus.o_count    = count;
    bus.o_full     = full;
    bus.o_empty    = empty;
    bus.o_overflow = overflow;
    bus.o_irq      = (count >= IRQ_LVL);
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard for the wrap-around phase.
// Latency: inputs change 1 time unit after a rising edge and are sampled at the next edge.
// Backpressure: i_rd_ready is driven directly, randomized in the wrap phase.
module tb_uart_rx_fifo;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.P_UART_DATA_WIDTH(8), .P_FIFO_AWIDTH(4)) bus ();

  uart_rx_fifo #(
    .P_UART_DATA_WIDTH(8),
    .P_FIFO_AWIDTH(4),
    .P_IRQ_LEVEL(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Push n consecutive bytes base, base+1, ... with no pops.
  task automatic push_n(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = base + 8'(i);
      tick();
    end
    bus.i_wr_valid = 1'b0;
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp3 [3];
  logic [7:0] dat;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.i_wr_data   = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_rd_ready  = 1'b0;
    bus.i_ovf_clear = 1'b0;
    bus.i_flush     = 1'b0;
    #3;
    chk("rst_count",    32'(bus.o_count),    32'd0);
    chk("rst_empty",    32'(bus.o_empty),    32'd1);
    chk("rst_full",     32'(bus.o_full),     32'd0);
    chk("rst_valid",    32'(bus.o_rd_valid), 32'd0);
    chk("rst_ovf",      32'(bus.o_overflow), 32'd0);
    chk("rst_irq",      32'(bus.o_irq),      32'd0);
    #9 reset = 1'b0;
    tick();

    // Three pushes, then three back-to-back pops.
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'h41;
    tick();
    chk("first_valid", 32'(bus.o_rd_valid), 32'd1);
    chk("first_data",  32'(bus.o_rd_data),  32'h41);
    bus.i_wr_data = 8'h42;
    tick();
    bus.i_wr_data = 8'h43;
    tick();
    bus.i_wr_valid = 1'b0;
    chk("t1_count", 32'(bus.o_count),   32'd3);
    chk("t1_head",  32'(bus.o_rd_data), 32'h41);
    chk("t1_empty", 32'(bus.o_empty),   32'd0);
    chk("t1_irq",   32'(bus.o_irq),     32'd1);
    exp3[0] = 8'h41; exp3[1] = 8'h42; exp3[2] = 8'h43;
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_data", 32'(bus.o_rd_data), 32'(exp3[i]));
      tick();
    end
    chk("t1_drained_empty", 32'(bus.o_empty), 32'd1);
    chk("t1_drained_irq",   32'(bus.o_irq),   32'd0);
    tick();
    chk("pop_when_empty_count", 32'(bus.o_count), 32'd0);
    bus.i_rd_ready = 1'b0;

    // Fill to full, then one dropped push.
    push_n(8'h00, 16);
    chk("full_flag",  32'(bus.o_full),  32'd1);
    chk("full_count", 32'(bus.o_count), 32'd16);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'hFF;
    tick();
    bus.i_wr_valid = 1'b0;
    chk("drop_ovf",   32'(bus.o_overflow), 32'd1);
    chk("drop_count", 32'(bus.o_count),    32'd16);
    bus.i_ovf_clear = 1'b1;
    tick();
    bus.i_ovf_clear = 1'b0;
    chk("clear_ovf", 32'(bus.o_overflow), 32'd0);

    // Full with simultaneous push and pop: the push must be accepted.
    chk("pp_head", 32'(bus.o_rd_data), 32'h00);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'h55;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    chk("pp_count", 32'(bus.o_count),    32'd16);
    chk("pp_ovf",   32'(bus.o_overflow), 32'd0);
    bus.i_rd_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      dat = (i == 16) ? 8'h55 : 8'(i);
      chk("drain_data", 32'(bus.o_rd_data), 32'(dat));
      tick();
    end
    bus.i_rd_ready = 1'b0;
    chk("drain_empty", 32'(bus.o_empty), 32'd1);

    // Wrap-around with randomized pops against a queue model.
    begin
      int  sent;
      int  cyc;
      logic do_push;
      logic do_pop;
      sent = 0;
      cyc  = 0;
      while ((sent < 40 || sb.size() > 0) && cyc < 400) begin
        do_push = (sent < 40) && (sb.size() < 16) && ($urandom_range(0, 3) != 0);
        do_pop  = ($urandom_range(0, 1) == 1);
        bus.i_wr_valid = do_push;
        bus.i_wr_data  = 8'h80 + 8'(sent);
        bus.i_rd_ready = do_pop;
        if (sb.size() > 0) chk("wrap_data", 32'(bus.o_rd_data), 32'(sb[0]));
        tick();
        if (do_pop && sb.size() > 0) void'(sb.pop_front());
        if (do_push) begin
          sb.push_back(8'h80 + 8'(sent));
          sent++;
        end
        chk("wrap_count", 32'(bus.o_count), 32'(sb.size()));
        cyc++;
      end
      bus.i_wr_valid = 1'b0;
      bus.i_rd_ready = 1'b0;
      chk("wrap_budget", 32'(cyc < 400), 32'd1);
      chk("wrap_ovf",    32'(bus.o_overflow), 32'd0);
    end

    // Flush with five entries and a simultaneous push.
    push_n(8'hA0, 5);
    chk("pre_flush_count", 32'(bus.o_count), 32'd5);
    bus.i_flush    = 1'b1;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 8'hEE;
    tick();
    bus.i_flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    chk("flush_count", 32'(bus.o_count),    32'd0);
    chk("flush_valid", 32'(bus.o_rd_valid), 32'd0);
    chk("flush_ovf",   32'(bus.o_overflow), 32'd0);
    tick();
    chk("flush_push_gone", 32'(bus.o_count), 32'd0);

    // Flush with a push while full must not set overflow.
    push_n(8'h10, 16);
    bus.i_flush    = 1'b1;
    bus.i_wr_valid = 1'b1;
    tick();
    bus.i_flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    chk("flush_full_ovf",   32'(bus.o_overflow), 32'd0);
    chk("flush_full_count", 32'(bus.o_count),    32'd0);

    // Overflow together with clear: set wins.
    push_n(8'h20, 16);
    bus.i_wr_valid  = 1'b1;
    bus.i_wr_data   = 8'hFE;
    bus.i_ovf_clear = 1'b1;
    tick();
    bus.i_wr_valid  = 1'b0;
    bus.i_ovf_clear = 1'b0;
    chk("set_wins_ovf", 32'(bus.o_overflow), 32'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_keeps_ovf", 32'(bus.o_overflow), 32'd1);
    chk("flush2_count",    32'(bus.o_count),    32'd0);
    bus.i_ovf_clear = 1'b1;
    tick();
    bus.i_ovf_clear = 1'b0;
    chk("clear_alone_ovf", 32'(bus.o_overflow), 32'd0);

    // Asynchronous reset mid-stream.
    push_n(8'h30, 7);
    chk("pre_rst_count", 32'(bus.o_count), 32'd7);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(bus.o_count),    32'd0);
    chk("async_rst_empty", 32'(bus.o_empty),    32'd1);
    chk("async_rst_valid", 32'(bus.o_rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_count", 32'(bus.o_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
